// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues one read at a time on the instruction bus and
// presents the fetched word to IF/ID until it is consumed or a branch redirects.
module inst_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stop,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        stallreq_if
);

    localparam logic [31:0] RESET_PC  = 32'hBFC0_0000;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic [31:0] buffer, buffer_nx;
    logic        cancel, cancel_nx;

    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        buffer_nx = buffer;
        cancel_nx = cancel;
        case (state)
            S_REQ: begin
                if (branch_flag) begin
                    pc_nx     = branch_target;
                    buffer_nx = ZERO_WORD;
                end
                if (inst_addr_ok) begin
                    state_nx  = S_WAIT;
                    // A read accepted in the redirect cycle targets the old pc.
                    cancel_nx = branch_flag;
                end
            end
            S_WAIT: begin
                if (inst_data_ok) begin
                    cancel_nx = 1'b0;
                    if (cancel || branch_flag) begin
                        state_nx = S_REQ;
                        if (branch_flag) begin
                            pc_nx     = branch_target;
                            buffer_nx = ZERO_WORD;
                        end
                    end else begin
                        buffer_nx = inst_rdata;
                        state_nx  = S_HOLD;
                    end
                end else if (branch_flag) begin
                    pc_nx     = branch_target;
                    buffer_nx = ZERO_WORD;
                    cancel_nx = 1'b1;
                end
            end
            S_HOLD: begin
                if (branch_flag) begin
                    pc_nx     = branch_target;
                    buffer_nx = ZERO_WORD;
                    state_nx  = S_REQ;
                end else if (!stop[1]) begin
                    pc_nx    = pc + 32'd4;
                    state_nx = S_REQ;
                end
            end
            default: begin
                state_nx = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_REQ;
            pc     <= RESET_PC;
            buffer <= ZERO_WORD;
            cancel <= 1'b0;
        end else begin
            state  <= state_nx;
            pc     <= pc_nx;
            buffer <= buffer_nx;
            cancel <= cancel_nx;
        end
    end

    // Outputs depend only on registered state, never on bus inputs.
    assign inst_req    = (state == S_REQ);
    assign inst_addr   = pc;
    assign if_pc       = pc;
    assign if_inst     = (state == S_HOLD) ? buffer : ZERO_WORD;
    assign stallreq_if = (state != S_HOLD);

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios with literal expectations, then
// randomized bus/stall/branch traffic checked every cycle against a flag-based model.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  stop = '0;
    logic        branch_flag = 1'b0;
    logic [31:0] branch_target = '0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok = 1'b0;
    logic        inst_data_ok = 1'b0;
    logic [31:0] inst_rdata = '0;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        stallreq_if;

    int checks = 0;
    int errors = 0;

    inst_fetch dut (
        .clk(clk), .rst(rst), .stop(stop),
        .branch_flag(branch_flag), .branch_target(branch_target),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata),
        .if_pc(if_pc), .if_inst(if_inst), .stallreq_if(stallreq_if)
    );

    always #5 clk = ~clk;

    // Model: the fetch unit is either asking for an address, has one read in
    // flight (possibly doomed), or is holding an instruction for decode.
    logic        m_valid = 1'b0;
    logic [31:0] m_pc;
    logic        m_inflight;
    logic        m_doomed;
    logic        m_have;
    logic [31:0] m_inst;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic exp_req;
        exp_req = !m_have && !m_inflight;
        check("inst_req", {31'd0, inst_req}, {31'd0, exp_req});
        check("inst_addr", inst_addr, m_pc);
        check("if_pc", if_pc, m_pc);
        check("if_inst", if_inst, m_have ? m_inst : 32'd0);
        check("stallreq_if", {31'd0, stallreq_if}, {31'd0, !m_have});
    endtask

    task automatic model_step();
        if (rst) begin
            m_valid    = 1'b1;
            m_pc       = 32'hBFC0_0000;
            m_inflight = 1'b0;
            m_doomed   = 1'b0;
            m_have     = 1'b0;
            m_inst     = 32'd0;
        end else if (m_have) begin
            if (branch_flag) begin
                m_pc   = branch_target;
                m_have = 1'b0;
            end else if (!stop[1]) begin
                m_pc   = m_pc + 32'd4;
                m_have = 1'b0;
            end
        end else if (m_inflight) begin
            if (inst_data_ok) begin
                m_inflight = 1'b0;
                if (m_doomed || branch_flag) begin
                    m_doomed = 1'b0;
                    if (branch_flag) m_pc = branch_target;
                end else begin
                    m_have = 1'b1;
                    m_inst = inst_rdata;
                end
            end else if (branch_flag) begin
                m_doomed = 1'b1;
                m_pc     = branch_target;
            end
        end else begin
            if (inst_addr_ok) begin
                m_inflight = 1'b1;
                m_doomed   = branch_flag;
            end
            if (branch_flag) m_pc = branch_target;
        end
    endtask

    // Called at a negedge with inputs already set: checks outputs, advances
    // the model over the coming posedge, then waits for the next negedge.
    task automatic cycle();
        if (m_valid) compare_model();
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 1'b0; stop = '0; branch_flag = 1'b0; branch_target = '0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
    endtask

    task automatic fetch(input logic [31:0] word);
        idle_inputs(); stop = 6'b000010; inst_addr_ok = 1'b1; cycle();
        idle_inputs(); stop = 6'b000010; inst_data_ok = 1'b1; inst_rdata = word; cycle();
    endtask

    initial begin
        @(negedge clk);
        rst = 1'b1;
        cycle();
        cycle();
        idle_inputs();

        check("rst_req", {31'd0, inst_req}, 32'd1);
        check("rst_addr", inst_addr, 32'hBFC0_0000);
        check("rst_inst", if_inst, 32'd0);
        check("rst_stall", {31'd0, stallreq_if}, 32'd1);

        // Zero-bubble fetch of the first instruction.
        inst_addr_ok = 1'b1; cycle();
        idle_inputs(); inst_data_ok = 1'b1; inst_rdata = 32'h2401_0001; cycle();
        check("hold_pc", if_pc, 32'hBFC0_0000);
        check("hold_inst", if_inst, 32'h2401_0001);
        check("hold_stall", {31'd0, stallreq_if}, 32'd0);

        // Stall the hold for three cycles.
        idle_inputs(); stop = 6'b000010;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("stall_inst", if_inst, 32'h2401_0001);
            check("stall_req", {31'd0, inst_req}, 32'd0);
            check("stall_pc", if_pc, 32'hBFC0_0000);
        end
        idle_inputs(); cycle();
        check("next_addr", inst_addr, 32'hBFC0_0004);

        // Address not accepted for five cycles.
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("wait_addr_req", {31'd0, inst_req}, 32'd1);
            check("wait_addr", inst_addr, 32'hBFC0_0004);
            check("wait_addr_stall", {31'd0, stallreq_if}, 32'd1);
        end

        // Branch while a read is in flight; its data arrives two cycles later.
        inst_addr_ok = 1'b1; cycle();
        idle_inputs(); branch_flag = 1'b1; branch_target = 32'h8000_1000; cycle();
        idle_inputs(); cycle();
        inst_data_ok = 1'b1; inst_rdata = 32'hDEAD_BEEF; cycle();
        idle_inputs();
        check("redir_addr", inst_addr, 32'h8000_1000);
        check("redir_req", {31'd0, inst_req}, 32'd1);
        check("redir_stall", {31'd0, stallreq_if}, 32'd1);

        // Branch beats consumption in hold; then pc wraps past the top.
        fetch(32'h1111_2222);
        idle_inputs(); branch_flag = 1'b1; branch_target = 32'hFFFF_FFFC; cycle();
        idle_inputs();
        check("branch_pc", inst_addr, 32'hFFFF_FFFC);
        fetch(32'h3333_4444);
        check("top_inst", if_inst, 32'h3333_4444);
        idle_inputs(); cycle();
        check("wrap_addr", inst_addr, 32'h0000_0000);

        // Reset in the middle of a read; the late response must be ignored.
        inst_addr_ok = 1'b1; cycle();
        idle_inputs(); rst = 1'b1; cycle();
        idle_inputs();
        check("mid_rst_addr", inst_addr, 32'hBFC0_0000);
        check("mid_rst_req", {31'd0, inst_req}, 32'd1);
        check("mid_rst_inst", if_inst, 32'd0);
        inst_data_ok = 1'b1; inst_rdata = 32'h5555_AAAA; cycle();
        idle_inputs();
        check("stale_req", {31'd0, inst_req}, 32'd1);
        check("stale_stall", {31'd0, stallreq_if}, 32'd1);

        // Randomized traffic; the bus only answers reads it has accepted,
        // plus occasional spurious data strobes when nothing is in flight.
        for (int n = 0; n < 3000; n++) begin
            rst           = ($urandom_range(0, 99) < 2);
            stop          = 6'($urandom_range(0, 63));
            stop[1]       = ($urandom_range(0, 99) < 40);
            branch_flag   = ($urandom_range(0, 99) < 12);
            branch_target = $urandom;
            inst_addr_ok  = ($urandom_range(0, 99) < 50);
            inst_rdata    = $urandom;
            if (m_inflight) inst_data_ok = ($urandom_range(0, 99) < 45);
            else            inst_data_ok = ($urandom_range(0, 99) < 15);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
